// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for a bank of common-anode seven-segment digits.
// Each digit owns a slot of REFRESH_DIV clocks. The first BLANK_CYCLES clocks
// of a slot keep every anode off so the previous digit's segments cannot ghost
// into the next one. The display decodes only shadow copies of the inputs.
// These copies reload once per frame, so a digit pattern never tears while it
// is on screen.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous reset, active-low
//   value        hex nibbles, digit i = value[4i+3:4i], digit 0 rightmost
//   digit_en     1 = digit i may light
//   dp           1 = decimal point of digit i lit
//   lz_suppress  1 = blank leading zero digits (digit 0 never blanked)
//   seg          active-low segments {a,b,c,d,e,f,g}
//   dp_n         active-low decimal point
//   an           active-low anodes, an[i] = digit i
//   frame_tick   one-cycle pulse on the clock the shadow registers load
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    lz_suppress,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    // The state always describes the current cnt, so it starts in DRIVE
    // when there is no blanking window.
    localparam state_t RESET_STATE = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;

    logic [CW-1:0] cnt, cnt_next;
    logic [IW-1:0] idx, idx_next;
    state_t        state, state_next;
    logic          cnt_wrap, frame_end, blank_next;

    logic [4*NUM_DIGITS-1:0] sh_value;
    logic [NUM_DIGITS-1:0]   sh_en, sh_dp;
    logic                    sh_lz;

    logic [6:0]            seg_d;
    logic                  dp_n_d;
    logic [NUM_DIGITS-1:0] an_d;
    logic [NUM_DIGITS-1:0] supp;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        unique case (n)
            4'h0: hex7 = 7'b0000001;
            4'h1: hex7 = 7'b1001111;
            4'h2: hex7 = 7'b0010010;
            4'h3: hex7 = 7'b0000110;
            4'h4: hex7 = 7'b1001100;
            4'h5: hex7 = 7'b0100100;
            4'h6: hex7 = 7'b0100000;
            4'h7: hex7 = 7'b0001111;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0001100;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b1100000;
            4'hC: hex7 = 7'b0110001;
            4'hD: hex7 = 7'b1000010;
            4'hE: hex7 = 7'b0110000;
            default: hex7 = 7'b0111000;
        endcase
    endfunction

    // State register: slot counter, digit index and BLANK/DRIVE phase.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            idx   <= '0;
            state <= RESET_STATE;
        end else begin
            cnt   <= cnt_next;
            idx   <= idx_next;
            state <= state_next;
        end
    end

    // Next-state logic.
    // NOTE: each always_comb output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        cnt_wrap  = (cnt == CNT_LAST);
        frame_end = cnt_wrap && (idx == IDX_LAST);
        cnt_next  = cnt_wrap ? '0 : cnt + 1'b1;
        idx_next  = idx;
        if (cnt_wrap) begin
            idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
        state_next = blank_next ? ST_BLANK : ST_DRIVE;
    end

    // With no blanking window, the compare would be against zero, so it is
    // left out entirely.
    generate
        if (BLANK_CYCLES > 0) begin : g_blank
            localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);
            assign blank_next = (cnt_next < BLANK_LIM);
        end else begin : g_no_blank
            assign blank_next = 1'b0;
        end
    endgenerate

    // Output decode from the shadow copy. Digit i is suppressed when it and
    // every digit to its left are zero. Only the slot whose index matches can
    // light, so at most one anode is ever low.
    always_comb begin
        logic all_zero;
        seg_d    = 7'b1111111;
        dp_n_d   = 1'b1;
        an_d     = '1;
        supp     = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (sh_value[4*i +: 4] == 4'h0);
            supp[i]  = (i != 0) && sh_lz && all_zero;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (state == ST_DRIVE && idx == IW'(i) && sh_en[i] && !supp[i]) begin
                an_d[i] = 1'b0;
                seg_d   = hex7(sh_value[4*i +: 4]);
                dp_n_d  = ~sh_dp[i];
            end
        end
    end

    // Registered pin drivers. The asynchronous reset blanks the display
    // immediately, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= 7'b1111111;
            dp_n       <= 1'b1;
            an         <= '1;
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_d;
            dp_n       <= dp_n_d;
            an         <= an_d;
            frame_tick <= frame_end;
        end
    end

    // Shadow registers load only at the frame boundary.
    // NOTE: shadow registers are reset, so the cleared digit enable keeps the
    // display dark until the first frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_value <= '0;
            sh_en    <= '0;
            sh_dp    <= '0;
            sh_lz    <= 1'b0;
        end else if (frame_end) begin
            sh_value <= value;
            sh_en    <= digit_en;
            sh_dp    <= dp;
            sh_lz    <= lz_suppress;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4 and
// BLANK_CYCLES=1.
// Each table entry gives the inputs for one frame, together with the
// hand-decoded picture that the following frame must show. Inputs for the
// next entry change in the middle of the current frame, so every transition
// also checks that the display does not tear. Hand-written sequences cover
// the reset-hold state, the dark first frame, and an asynchronous reset
// asserted while a digit is lit.
module tb_seg7_scan_driver;

    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   value;
    logic [3:0]    digit_en, dp;
    logic          lz_suppress;
    logic [6:0]    seg;
    logic          dp_n;
    logic [3:0]    an;
    logic          frame_tick;

    int n_vec  = 0;
    int n_fail = 0;

    seg7_scan_driver #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (4),
        .BLANK_CYCLES(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .digit_en   (digit_en),
        .dp         (dp),
        .lz_suppress(lz_suppress),
        .seg        (seg),
        .dp_n       (dp_n),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0]     value;
        logic [3:0]      en;
        logic [3:0]      dp;
        logic            lz;
        logic [3:0]      lit;   // digits expected to light in the next frame
        logic [3:0][6:0] seg;   // expected segments per digit when lit
        logic [3:0]      dpn;   // expected dp_n per digit when lit
    } vec_t;

    vec_t vecs[7];
    vec_t dark;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        value       = v.value;
        digit_en    = v.en;
        dp          = v.dp;
        lz_suppress = v.lz;
    endtask

    // One rising edge, then return at the falling edge for sampling and driving.
    task automatic tick();
        @(negedge clk);
    endtask

    // Walk one 16-clock frame and check every cycle. Slot d covers 4 clocks:
    // the first is blank and the next 3 show digit d. frame_tick is expected on
    // the last clock. If nxt_valid is set, nxt is driven mid-frame.
    task automatic check_frame(input string tag, input vec_t e, input vec_t nxt, input bit nxt_valid);
        for (int d = 0; d < ND; d++) begin
            for (int c = 0; c < 4; c++) begin
                logic       lit_now;
                logic [3:0] exp_an;
                logic [6:0] exp_seg;
                logic       exp_dpn;
                if (d == 1 && c == 2 && nxt_valid) apply(nxt);
                tick();
                lit_now = (c != 0) && e.lit[d];
                exp_an  = lit_now ? ~(4'b0001 << d) : 4'b1111;
                exp_seg = lit_now ? e.seg[d] : 7'b1111111;
                exp_dpn = lit_now ? e.dpn[d] : 1'b1;
                check($sformatf("%s d%0d c%0d an", tag, d, c), 32'(an), 32'(exp_an));
                check($sformatf("%s d%0d c%0d seg", tag, d, c), 32'(seg), 32'(exp_seg));
                check($sformatf("%s d%0d c%0d dp_n", tag, d, c), 32'(dp_n), 32'(exp_dpn));
                check($sformatf("%s d%0d c%0d frame_tick", tag, d, c), 32'(frame_tick),
                      32'(d == ND - 1 && c == 3));
            end
        end
    endtask

    initial begin
        // Segment patterns are listed in the order {d3, d2, d1, d0}.
        dark = '{value: 16'h0, en: 4'h0, dp: 4'h0, lz: 1'b0, lit: 4'b0000,
                 seg: {4{7'b1111111}}, dpn: 4'b1111};
        vecs[0] = '{value: 16'h1234, en: 4'b1111, dp: 4'b0000, lz: 1'b0, lit: 4'b1111,
                    seg: {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, dpn: 4'b1111};
        vecs[1] = '{value: 16'hABCD, en: 4'b1111, dp: 4'b0000, lz: 1'b0, lit: 4'b1111,
                    seg: {7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010}, dpn: 4'b1111};
        vecs[2] = '{value: 16'h0050, en: 4'b1111, dp: 4'b0000, lz: 1'b1, lit: 4'b0011,
                    seg: {7'b1111111, 7'b1111111, 7'b0100100, 7'b0000001}, dpn: 4'b1111};
        vecs[3] = '{value: 16'h0000, en: 4'b1111, dp: 4'b0000, lz: 1'b1, lit: 4'b0001,
                    seg: {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, dpn: 4'b1111};
        vecs[4] = '{value: 16'h8765, en: 4'b0101, dp: 4'b0100, lz: 1'b0, lit: 4'b0101,
                    seg: {7'b1111111, 7'b0001111, 7'b1111111, 7'b0100100}, dpn: 4'b1011};
        // The suppressed digit 3 has its dp set, but the dp must stay dark.
        vecs[5] = '{value: 16'h0F00, en: 4'b1111, dp: 4'b1000, lz: 1'b1, lit: 4'b0111,
                    seg: {7'b1111111, 7'b0111000, 7'b0000001, 7'b0000001}, dpn: 4'b1111};
        vecs[6] = '{value: 16'h9E86, en: 4'b1111, dp: 4'b1111, lz: 1'b0, lit: 4'b1111,
                    seg: {7'b0001100, 7'b0110000, 7'b0000000, 7'b0100000}, dpn: 4'b0000};

        // Reset held for 3 clocks.
        rst_n = 1'b0;
        apply(vecs[0]);
        repeat (3) tick();
        check("reset an", 32'(an), 32'hF);
        check("reset seg", 32'(seg), 32'h7F);
        check("reset dp_n", 32'(dp_n), 32'h1);
        check("reset frame_tick", 32'(frame_tick), 32'h0);
        rst_n = 1'b1;

        // First frame after reset stays dark and ends with frame_tick.
        check_frame("first", dark, dark, 1'b0);

        for (int j = 0; j < 7; j++) begin
            check_frame($sformatf("vec%0d", j), vecs[j], vecs[(j < 6) ? j + 1 : 6], j < 6);
        end

        // Reset during a lit cycle of digit 2 (vecs[6] still applied).
        repeat (10) tick();
        check("pre-reset an", 32'(an), 32'b1011);
        #2 rst_n = 1'b0;
        #1;
        check("async reset an", 32'(an), 32'hF);
        check("async reset seg", 32'(seg), 32'h7F);
        check("async reset dp_n", 32'(dp_n), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        check_frame("post-reset dark", dark, dark, 1'b0);
        check_frame("post-reset vec6", vecs[6], dark, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
